// File: rtl/seg7_pkg.sv
// seg7_pkg: FSM state encoding and active-low gfedcba segment patterns for the scan driver
`timescale 1ns/1ps
package seg7_pkg;

    typedef enum logic [1:0] {IDLE, GUARD, DRIVE} state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: combinational hex digit to active-low seven-segment pattern
`timescale 1ns/1ps
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] d,
    output logic [6:0] seg
);

    // full hex table; F falls through to the default
    always_comb begin
        case (d)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'ha:    seg = SEG_A;
            4'hb:    seg = SEG_B;
            4'hc:    seg = SEG_C;
            4'hd:    seg = SEG_D;
            4'he:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed common-anode display scanner with anti-ghosting guard slots
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
`timescale 1ns/1ps
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int GUARD_CYCLES = 500
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int CMAX = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dp_q;
    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [6:0]              dec;
    logic                    blank;

    seg7_decode u_dec (
        .d   (digits_q[{idx, 2'b00} +: 4]),
        .seg (dec)
    );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // a digit is a leading zero when it and every digit above it is zero; digit 0 always shows
    assign blank = (idx != '0) && ((digits_q >> {idx, 2'b00}) == '0);
`else
    assign blank = 1'b0;
`endif

    // shadow copy of the digit vector, overwritten by every load regardless of scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            dp_q     <= '0;
        end else if (load) begin
            digits_q <= digits;
            dp_q     <= dp_mask;
        end
    end

    // scan FSM; segment/dp registers latch on entry to DRIVE so a mid-slot load cannot disturb the lit digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            an    <= '1;
            seg   <= SEG_BLANK;
            dp_n  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= GUARD;
                        cnt   <= CW'(GUARD_CYCLES - 1);
                        idx   <= '0;
                    end
                end
                GUARD: begin
                    if (cnt == '0) begin
                        state <= DRIVE;
                        cnt   <= CW'(REFRESH_DIV - 1);
                        an    <= ~(ONE << idx);
                        seg   <= blank ? SEG_BLANK : dec;
                        dp_n  <= ~dp_q[idx];
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DRIVE: begin
                    if (cnt == '0) begin
                        state <= GUARD;
                        cnt   <= CW'(GUARD_CYCLES - 1);
                        idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
                        an    <= '1;
                        seg   <= SEG_BLANK;
                        dp_n  <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench; stimulus queues per-cycle expected outputs, a negedge monitor checks them
`timescale 1ns/1ps
module tb_seg7_scan_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] BL = 7'b1111111;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZL = BL;
`else
    localparam logic [6:0] ZL = S0;
`endif

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp_n;
        string      tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;

    exp_t q[$];
    exp_t e;
    int   checks = 0;
    int   passed = 0;

    seg7_scan_driver #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .GUARD_CYCLES (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .digits  (digits),
        .dp_mask (dp_mask),
        .seg     (seg),
        .dp_n    (dp_n),
        .an      (an)
    );

    always #5 clk = ~clk;

    // monitor: compare the outputs of every queued cycle mid-cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (an === e.an && seg === e.seg && dp_n === e.dp_n)
                passed++;
            else
                $display("FAIL %s: got an=%b seg=%b dp_n=%b, want an=%b seg=%b dp_n=%b",
                         e.tag, an, seg, dp_n, e.an, e.seg, e.dp_n);
        end
    end

    task automatic step(input logic [3:0] a, input logic [6:0] s, input logic d, input string t);
        q.push_back('{a, s, d, t});
        @(posedge clk);
        #1;
    endtask

    task automatic blank_n(input int n, input string t);
        repeat (n) step(4'b1111, BL, 1'b1, t);
    endtask

    task automatic slot(input logic [3:0] a, input logic [6:0] s, input logic d, input string t);
        repeat (4) step(a, s, d, t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; load = 1'b0; digits = '0; dp_mask = '0;
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        blank_n(2, "reset");
        rst_n = 1'b1;
        blank_n(20, "idle_no_load");
        digits = 16'h1234; dp_mask = 4'b0010; load = 1'b1;
        blank_n(1, "load_cycle");
        load = 1'b0;
        blank_n(1, "first_guard");
        slot(4'b1110, S4, 1'b1, "d0_4");
        blank_n(1, "guard");
        slot(4'b1101, S3, 1'b0, "d1_3_dp");
        blank_n(1, "guard");
        slot(4'b1011, S2, 1'b1, "d2_2");
        blank_n(1, "guard");
        slot(4'b0111, S1, 1'b1, "d3_1");
        blank_n(1, "guard");
        slot(4'b1110, S4, 1'b1, "d0_again");
        blank_n(1, "guard");
        repeat (2) step(4'b1101, S3, 1'b0, "d1_before_load");
        digits = 16'h5678; load = 1'b1;
        step(4'b1101, S3, 1'b0, "d1_load_in_slot");
        load = 1'b0;
        step(4'b1101, S3, 1'b0, "d1_held");
        blank_n(1, "guard");
        slot(4'b1011, S6, 1'b1, "d2_new_6");
        blank_n(1, "guard");
        slot(4'b0111, S5, 1'b1, "d3_new_5");
        digits = 16'h00A0; dp_mask = 4'b0000; load = 1'b1;
        blank_n(1, "guard_edge_load");
        load = 1'b0;
        slot(4'b1110, S8, 1'b1, "d0_pre_edge_8");
        blank_n(1, "guard");
        slot(4'b1101, SA, 1'b1, "a0_d1_A");
        blank_n(1, "guard");
        slot(4'b1011, ZL, 1'b1, "a0_d2_lead0");
        blank_n(1, "guard");
        slot(4'b0111, ZL, 1'b1, "a0_d3_lead0");
        blank_n(1, "guard");
        slot(4'b1110, S0, 1'b1, "a0_d0_0");
        blank_n(1, "guard");
        digits = 16'h0000; load = 1'b1;
        step(4'b1101, SA, 1'b1, "a0_d1_load");
        load = 1'b0;
        repeat (3) step(4'b1101, SA, 1'b1, "a0_d1_held");
        blank_n(1, "guard");
        slot(4'b1011, ZL, 1'b1, "z_d2_stale");
        blank_n(1, "guard");
        slot(4'b0111, ZL, 1'b1, "z_d3");
        blank_n(1, "guard");
        slot(4'b1110, S0, 1'b1, "z_d0");
        blank_n(1, "guard");
        slot(4'b1101, ZL, 1'b1, "z_d1");
        blank_n(1, "guard");
        step(4'b1011, ZL, 1'b1, "pre_reset_lit");
        q.push_back('{4'b1111, BL, 1'b1, "async_reset_blank"});
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        blank_n(10, "post_reset_idle");
        digits = 16'h1234; dp_mask = 4'b0001; load = 1'b1;
        blank_n(1, "reload_cycle");
        load = 1'b0;
        blank_n(1, "reload_guard");
        slot(4'b1110, S4, 1'b0, "restart_d0");
        checks++;
        if (q.size() == 0)
            passed++;
        else
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
